// File: rtl/fm_pkg.sv
// Shared constants and types for the baseband CIC decimator.
//   CIC_N      number of integrator / comb stages
//   CIC_R      nominal decimation ratio (960 kHz -> 32 kHz)
//   CIC_ACC_W  accumulator width = input width + ceil(N*log2(R))
package fm_pkg;

    localparam int CIC_N     = 4;
    localparam int CIC_R     = 30;
    localparam int CIC_ACC_W = 16 + $clog2(CIC_R ** CIC_N);

    typedef logic signed [CIC_ACC_W-1:0] cic_acc_t;

    typedef enum logic [1:0] {IDLE, COMB, OUT} cic_state_t;

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: an enabled modulo-2^W accumulator.
//   clk  in   clock
//   rst  in   asynchronous active-high reset, clears the accumulator
//   en   in   accumulate enable (input-rate strobe)
//   din  in   W-bit addend (previous stage's registered output)
//   acc  out  W-bit accumulator value
module cic_integrator #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    // Wrap-around is intended; the combs undo it as long as W covers the gain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= acc + din;
    end

endmodule

// File: rtl/cic_decim_960k_32k.sv
// N-stage CIC decimator (M=1), 960 kHz in, 32 kHz out, all on clk240m.
// Integrators run on en960k; at en32k the last integrator is captured and a
// sequencer runs the N comb stages one per clock, then publishes the MSBs.
//   clk240m    in   system clock
//   rst240m    in   asynchronous active-high reset
//   en960k     in   input-rate strobe, in_data valid this cycle
//   en32k      in   output-rate strobe (decimation instant)
//   in_data    in   signed IN_W sample
//   out_data   out  signed OUT_W decimated sample, held between updates
//   out_valid  out  one-cycle pulse, N+1 cycles after the accepted en32k
module cic_decim_960k_32k
    import fm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int N     = CIC_N,
    parameter int R     = CIC_R
) (
    input  logic                    clk240m,
    input  logic                    rst240m,
    input  logic                    en960k,
    input  logic                    en32k,
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid
);

    localparam int ACC_W = IN_W + $clog2(R ** N);
    localparam int SW    = (N > 1) ? $clog2(N) : 1;

    // ichain[0] is the sign-extended input, ichain[k] is integrator k.
    logic [ACC_W-1:0] ichain [N+1];

    assign ichain[0] = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    for (genvar g = 0; g < N; g++) begin : g_int
        cic_integrator #(.W(ACC_W)) u_int (
            .clk (clk240m),
            .rst (rst240m),
            .en  (en960k),
            .din (ichain[g]),
            .acc (ichain[g+1])
        );
    end

    cic_state_t       state, state_nx;
    logic [SW-1:0]    stg;          // comb stage being processed (0 = first)
    logic [ACC_W-1:0] cap;          // last integrator at the decimation instant
    logic [ACC_W-1:0] ypipe;        // output of the previous comb stage
    logic [ACC_W-1:0] dly [N];      // one-sample comb delays
    logic [ACC_W-1:0] yin, ynew;
    logic             start, last;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        last     = (stg == SW'(N-1));
        yin      = (stg == '0) ? cap : ypipe;
        ynew     = yin - dly[stg];
        case (state)
            // en32k in COMB/OUT is dropped: only one decimation in flight.
            IDLE:    if (en32k) begin
                         start    = 1'b1;
                         state_nx = COMB;
                     end
            COMB:    if (last) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk240m or posedge rst240m) begin
        if (rst240m) begin
            state     <= IDLE;
            stg       <= '0;
            cap       <= '0;
            ypipe     <= '0;
            for (int i = 0; i < N; i++) dly[i] <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            if (start) begin
                // Registered value, i.e. before any same-cycle en960k update.
                cap <= ichain[N];
                stg <= '0;
            end
            if (state == COMB) begin
                dly[stg] <= yin;
                ypipe    <= ynew;
                stg      <= stg + SW'(1);
                // Publish on the last stage so data and pulse appear together
                // in the OUT cycle.
                if (last) begin
                    out_data  <= ynew[ACC_W-1 -: OUT_W];
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
